game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game sequencer for the Pac-Man design. It owns the play/ready/death/level-clear/game-over flow, the lives and level counters, and the freeze, respawn and bean-reload controls. These controls gate the Pac-Man key controller, the ghost mover and the bean map. It replaces the sticky one-shot over flag with a multi-life, multi-level state machine timed in video frames.

## Interface
Parameters:
- LIVES, 3: lives granted at game start (1..3).
- READY_FRAMES, 60: frame ticks spent in READY before play.
- DEATH_FRAMES, 120: frame ticks spent in DYING.
- CLEAR_FRAMES, 90: frame ticks spent in CLEAR.
- MAX_LEVEL, 9: last level (1..15); clearing it wins the game.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  one-cycle pulse from key or keyboard.
- pause  in  1  one-cycle pulse; toggles pause.
- crash  in  1  level from ghost-crash checker.
- beans_clear  in  1  level; all beans eaten.
- state  out  3  IDLE=0, READY=1, PLAY=2, PAUSE=3, DYING=4, CLEAR=5, OVER=6.
- freeze  out  1  actors hold position; 1 in every state except PLAY.
- respawn  out  1  one-cycle pulse; Pac-Man and ghosts return to home tiles.
- reload_beans  out  1  one-cycle pulse; bean map refilled.
- lives  out  2  remaining lives.
- level  out  4  current level, 1-based; 0 in IDLE after reset.
- over  out  1  equals (state==OVER); drives display overlay.
- win  out  1  set when game ends by clearing MAX_LEVEL; cleared on new game.

## Operation
- Reset (rst==0 at a clock edge) sets the following, and these are the only reset values: state=IDLE, lives=0, level=0, win=0, respawn=0, reload_beans=0, frame counter=0, freeze=1, over=0.
- IDLE:
  - On start: go to READY.
  - Load lives=LIVES, level=1, win=0.
  - Pulse respawn and reload_beans.
- READY: after READY_FRAMES frame ticks, go to PLAY.
- PLAY, checked in this priority order:
  - beans_clear: go to CLEAR.
  - Else crash: go to DYING.
  - Else pause: go to PAUSE.
  - beans_clear beats crash on the same cycle, so eating the last bean while touching a ghost still clears the level.
- PAUSE:
  - pause returns to PLAY.
  - crash and beans_clear are ignored.
  - start is ignored.
  - The frame counter does not run.
- DYING, after DEATH_FRAMES ticks:
  - If lives==1: lives=0, go to OVER.
  - Else: lives-=1, pulse respawn, go to READY.
- CLEAR, after CLEAR_FRAMES ticks:
  - If level==MAX_LEVEL: win=1, go to OVER.
  - Else: level+=1, pulse respawn and reload_beans, go to READY.
- OVER:
  - Hold lives, level and win.
  - On start, go to IDLE. A second start is then needed to begin a new game.
- Frame counter:
  - 8-bit. Cleared on every state change.
  - Increments only on frame_tick in READY, DYING and CLEAR.
  - The timed state exits on the frame_tick edge where counter==N-1, i.e. exactly N ticks.
  - N=0 is illegal.
- Pulse inputs (start, pause) that arrive in states that do not use them are dropped, not queued.

## Timing
- All outputs are registered.
- state, lives, level and win change on the edge that samples the triggering input: 1-cycle latency.
- respawn and reload_beans are high for exactly the first cycle in which state shows the new value.
- freeze and over are decoded from the state register, glitch-free, and valid in the same cycle as state.
- A frame_tick coincident with a state change is not counted toward the new state.
- Reset asserted mid-DYING or mid-CLEAR aborts immediately: no respawn or reload pulse is emitted.
- lives never underflows; level never exceeds MAX_LEVEL.

## Test plan
Directed scenarios use READY_FRAMES=2, DEATH_FRAMES=3, CLEAR_FRAMES=2, MAX_LEVEL=2, LIVES=3.

- Reset, then start:
  - Next cycle: state=1, lives=3, level=1, respawn=1 and reload_beans=1 for one cycle.
  - After 2 frame ticks: state=2, freeze=0.
- PLAY, crash held:
  - state=4.
  - After 3 ticks: state=1, lives=2, respawn pulse.
  - Repeat crash twice more: final state=6, lives=0, over=1, win=0.
- PLAY, beans_clear and crash asserted in the same cycle:
  - state=5, lives unchanged.
  - After 2 ticks: level=2, state=1, reload_beans pulse.
  - Clear again: state=6, win=1.
- PLAY, pause pulse:
  - state=3, freeze=1.
  - crash asserted and frame ticks applied: no change.
  - Second pause: state=2.
- rst low for one cycle during DYING with counter=2:
  - Next cycle: state=0, lives=0, level=0, no respawn pulse.
- OVER, then start: state=0. Second start: lives=3, level=1, win=0.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Pac-Man game sequencer: ready/play/pause/death/level-clear/game-over flow,
// lives and level bookkeeping, and the freeze/respawn/bean-reload controls.
module game_flow_ctrl #(
  parameter int LIVES        = 3,
  parameter int READY_FRAMES = 60,
  parameter int DEATH_FRAMES = 120,
  parameter int CLEAR_FRAMES = 90,
  parameter int MAX_LEVEL    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       crash,
  input  logic       beans_clear,
  output logic [2:0] state,
  output logic       freeze,
  output logic       respawn,
  output logic       reload_beans,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic       over,
  output logic       win
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_DYING = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [3:0] LEVEL_LAST = 4'(MAX_LEVEL);

  state_t     cur;
  state_t     nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [7:0] timer_last;
  logic       timed;
  logic       timer_done;
  logic [1:0] lives_nxt;
  logic [3:0] level_nxt;
  logic       win_nxt;
  logic       respawn_nxt;
  logic       reload_nxt;

  // Saturating counters keep lives from wrapping and level within range.
  function automatic logic [1:0] lives_dec(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

  function automatic logic [3:0] level_inc(input logic [3:0] l);
    return (l >= LEVEL_LAST) ? LEVEL_LAST : l + 4'd1;
  endfunction

  always_comb begin
    timer_last = 8'd0;
    timed      = 1'b0;
    case (cur)
      S_READY: begin timer_last = READY_LAST; timed = 1'b1; end
      S_DYING: begin timer_last = DEATH_LAST; timed = 1'b1; end
      S_CLEAR: begin timer_last = CLEAR_LAST; timed = 1'b1; end
      default: begin timer_last = 8'd0;       timed = 1'b0; end
    endcase
    timer_done = timed && frame_tick && (cnt == timer_last);
  end

  always_comb begin
    nxt         = cur;
    lives_nxt   = lives;
    level_nxt   = level;
    win_nxt     = win;
    respawn_nxt = 1'b0;
    reload_nxt  = 1'b0;
    case (cur)
      S_IDLE: begin
        if (start) begin
          nxt         = S_READY;
          lives_nxt   = LIVES_INIT;
          level_nxt   = 4'd1;
          win_nxt     = 1'b0;
          respawn_nxt = 1'b1;
          reload_nxt  = 1'b1;
        end
      end
      S_READY: begin
        if (timer_done) nxt = S_PLAY;
      end
      S_PLAY: begin
        // A last bean eaten while touching a ghost still counts as a clear.
        if (beans_clear)  nxt = S_CLEAR;
        else if (crash)   nxt = S_DYING;
        else if (pause)   nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (pause) nxt = S_PLAY;
      end
      S_DYING: begin
        if (timer_done) begin
          lives_nxt = lives_dec(lives);
          if (lives <= 2'd1) begin
            nxt = S_OVER;
          end else begin
            nxt         = S_READY;
            respawn_nxt = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (timer_done) begin
          if (level >= LEVEL_LAST) begin
            nxt     = S_OVER;
            win_nxt = 1'b1;
          end else begin
            nxt         = S_READY;
            level_nxt   = level_inc(level);
            respawn_nxt = 1'b1;
            reload_nxt  = 1'b1;
          end
        end
      end
      S_OVER: begin
        if (start) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase

    // Ticks coincident with a transition belong to the old state.
    if (nxt != cur)              cnt_nxt = 8'd0;
    else if (timed && frame_tick) cnt_nxt = cnt + 8'd1;
    else                          cnt_nxt = cnt;
  end

  // freeze and over are registered from the next state so they align with state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur          <= S_IDLE;
      cnt          <= 8'd0;
      lives        <= 2'd0;
      level        <= 4'd0;
      win          <= 1'b0;
      respawn      <= 1'b0;
      reload_beans <= 1'b0;
      freeze       <= 1'b1;
      over         <= 1'b0;
    end else begin
      cur          <= nxt;
      cnt          <= cnt_nxt;
      lives        <= lives_nxt;
      level        <= level_nxt;
      win          <= win_nxt;
      respawn      <= respawn_nxt;
      reload_beans <= reload_nxt;
      freeze       <= (nxt != S_PLAY);
      over         <= (nxt == S_OVER);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus queues expected transition
// snapshots with their cycle; a negedge monitor pops one per observed event.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       crash = 1'b0;
  logic       beans_clear = 1'b0;
  logic [2:0] state;
  logic       freeze;
  logic       respawn;
  logic       reload_beans;
  logic [1:0] lives;
  logic [3:0] level;
  logic       over;
  logic       win;

  game_flow_ctrl #(
    .LIVES(3), .READY_FRAMES(2), .DEATH_FRAMES(3), .CLEAR_FRAMES(2), .MAX_LEVEL(2)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
    .crash(crash), .beans_clear(beans_clear), .state(state), .freeze(freeze),
    .respawn(respawn), .reload_beans(reload_beans), .lives(lives), .level(level),
    .over(over), .win(win)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [1:0] lv;
    logic [3:0] lvl;
    logic       w;
    logic       fr;
    logic       ov;
    logic       rs;
    logic       rl;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  exp_t none;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;
  logic have_prev = 1'b0;
  logic [11:0] prev;
  logic [11:0] obs;

  function automatic exp_t mk(input logic [2:0] st, input logic [1:0] lv,
                              input logic [3:0] lvl, input logic w,
                              input logic rs, input logic rl);
    exp_t e;
    e.cyc = 0;
    e.st  = st;
    e.lv  = lv;
    e.lvl = lvl;
    e.w   = w;
    e.fr  = (st != 3'd2);
    e.ov  = (st == 3'd6);
    e.rs  = rs;
    e.rl  = rl;
    return e;
  endfunction

  // Event = any change of the persistent outputs, or any pulse output high.
  always @(negedge clk) begin
    if (mon_en) begin
      obs = {state, lives, level, win, freeze, over};
      if (have_prev && (obs != prev || respawn || reload_beans)) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event cyc=%0d st=%0d lives=%0d level=%0d win=%b frz=%b over=%b rs=%b rl=%b",
                   cyc, state, lives, level, win, freeze, over, respawn, reload_beans);
        end else begin
          got_e = sb.pop_front();
          if (cyc != got_e.cyc || state !== got_e.st || lives !== got_e.lv ||
              level !== got_e.lvl || win !== got_e.w || freeze !== got_e.fr ||
              over !== got_e.ov || respawn !== got_e.rs || reload_beans !== got_e.rl) begin
            miscompares++;
            $display("FAIL event got cyc=%0d st=%0d lives=%0d level=%0d win=%b frz=%b over=%b rs=%b rl=%b expected cyc=%0d st=%0d lives=%0d level=%0d win=%b frz=%b over=%b rs=%b rl=%b",
                     cyc, state, lives, level, win, freeze, over, respawn, reload_beans,
                     got_e.cyc, got_e.st, got_e.lv, got_e.lvl, got_e.w, got_e.fr, got_e.ov, got_e.rs, got_e.rl);
          end
        end
      end
      prev = obs;
      have_prev = 1'b1;
    end
  end

  task automatic step(input logic s, input logic p, input logic c, input logic b,
                      input logic f, input logic has, input exp_t e);
    @(negedge clk);
    if (has) begin
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    start = s; pause = p; crash = c; beans_clear = b; frame_tick = f;
    @(negedge clk);
    start = 1'b0; pause = 1'b0; crash = 1'b0; beans_clear = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n, input logic has, input exp_t e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (has && i == n - 1) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    none = mk(3'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({state, lives, level, win, freeze, over, respawn, reload_beans} !==
        {3'd0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got st=%0d lives=%0d level=%0d win=%b frz=%b over=%b rs=%b rl=%b expected st=0 lives=0 level=0 win=0 frz=1 over=0 rs=0 rl=0",
               state, lives, level, win, freeze, over, respawn, reload_beans);
    end
    mon_en = 1'b1;
    @(negedge clk);

    // New game, pause dropped in READY, then three deaths to game over.
    step(1, 0, 0, 0, 0, 1, mk(3'd1, 2'd3, 4'd1, 0, 1, 1));
    step(0, 1, 0, 0, 0, 0, none);
    ticks(2, 1, mk(3'd2, 2'd3, 4'd1, 0, 0, 0));
    step(0, 0, 1, 0, 0, 1, mk(3'd4, 2'd3, 4'd1, 0, 0, 0));
    ticks(3, 1, mk(3'd1, 2'd2, 4'd1, 0, 1, 0));
    ticks(2, 1, mk(3'd2, 2'd2, 4'd1, 0, 0, 0));
    step(0, 0, 1, 0, 0, 1, mk(3'd4, 2'd2, 4'd1, 0, 0, 0));
    ticks(3, 1, mk(3'd1, 2'd1, 4'd1, 0, 1, 0));
    ticks(2, 1, mk(3'd2, 2'd1, 4'd1, 0, 0, 0));
    step(0, 0, 1, 0, 0, 1, mk(3'd4, 2'd1, 4'd1, 0, 0, 0));
    ticks(3, 1, mk(3'd6, 2'd0, 4'd1, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, none);
    step(1, 0, 0, 0, 0, 1, mk(3'd0, 2'd0, 4'd1, 0, 0, 0));
    step(0, 1, 0, 0, 0, 0, none);

    // Clear beats crash, level advances, clearing the last level wins.
    step(1, 0, 0, 0, 0, 1, mk(3'd1, 2'd3, 4'd1, 0, 1, 1));
    ticks(2, 1, mk(3'd2, 2'd3, 4'd1, 0, 0, 0));
    step(0, 0, 1, 1, 0, 1, mk(3'd5, 2'd3, 4'd1, 0, 0, 0));
    ticks(2, 1, mk(3'd1, 2'd3, 4'd2, 0, 1, 1));
    ticks(2, 1, mk(3'd2, 2'd3, 4'd2, 0, 0, 0));
    step(0, 0, 0, 1, 0, 1, mk(3'd5, 2'd3, 4'd2, 0, 0, 0));
    ticks(2, 1, mk(3'd6, 2'd3, 4'd2, 1, 0, 0));

    // Restart; the tick coincident with entering READY must not count.
    step(1, 0, 0, 0, 0, 1, mk(3'd0, 2'd3, 4'd2, 1, 0, 0));
    step(1, 0, 0, 0, 1, 1, mk(3'd1, 2'd3, 4'd1, 0, 1, 1));
    ticks(2, 1, mk(3'd2, 2'd3, 4'd1, 0, 0, 0));

    // Pause ignores crash, beans_clear, start and frame ticks.
    step(0, 1, 0, 0, 0, 1, mk(3'd3, 2'd3, 4'd1, 0, 0, 0));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0, none);
    step(0, 0, 0, 1, 1, 0, none);
    step(1, 0, 0, 0, 0, 0, none);
    step(0, 1, 0, 0, 0, 1, mk(3'd2, 2'd3, 4'd1, 0, 0, 0));

    // Reset two ticks into DYING aborts with no pulses.
    step(0, 0, 1, 0, 0, 1, mk(3'd4, 2'd3, 4'd1, 0, 0, 0));
    ticks(2, 0, none);
    @(negedge clk);
    got_e = mk(3'd0, 2'd0, 4'd0, 0, 0, 0);
    got_e.cyc = cyc + 1;
    sb.push_back(got_e);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ticks(3, 0, none);
    step(1, 0, 0, 0, 0, 1, mk(3'd1, 2'd3, 4'd1, 0, 1, 1));
    ticks(2, 1, mk(3'd2, 2'd3, 4'd1, 0, 0, 0));

    repeat (5) @(negedge clk);
    while (sb.size() > 0) begin
      got_e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event expected cyc=%0d st=%0d lives=%0d level=%0d got none by cyc=%0d",
               got_e.cyc, got_e.st, got_e.lv, got_e.lvl, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
